// File: rtl/nvdla_attn_softmax.sv
// Row-wise softmax: base-2 linear exp, one restoring reciprocal per row, 8-lane normalize.
// Define ATTN_SOFTMAX_MASK_EN to build the causal mask (col > row excluded).
module nvdla_attn_softmax #(
  parameter int MAX_COLS  = 256,
  parameter int DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  cfg_rows,
  input  logic [15:0]  cfg_cols,
  input  logic         s_valid,
  input  logic [127:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [127:0] m_data,
  output logic [31:0]  m_addr,
  input  logic         m_ready,
  output logic         busy,
  output logic         done,
  output logic         error
);
  // state | meaning
  // IDLE  | wait for start, validate cfg
  // LOAD  | accept one row of scores, track max
  // EXP   | one element per cycle: e = 2^-(max-s), accumulate sum
  // DIV   | recip = floor(2^31 / sum)
  // EMIT  | stream e*recip per beat
  localparam int AW  = $clog2(MAX_COLS);
  localparam int BW  = AW - 3;
  localparam int DCW = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXP, S_DIV, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        rows_q, row_q;
  logic [AW:0]        cols_q;
  logic [BW-1:0]      beat_q;
  logic [AW-1:0]      idx_q;
  logic [DCW-1:0]     div_cnt_q;
  logic signed [15:0] max_q;
  logic [31:0]        sum_q, rem_q, dvd_q, base_q;
  logic [16:0]        quo_q;
  logic               done_q, error_q;
  logic [15:0]        buf_q [MAX_COLS];

  logic               cfg_bad, last_beat, last_idx, more_rows;
  logic [7:0]         lane_ok, lane_use;
  logic [15:0]        lane_s [8];
  logic [15:0]        lane_p [8];
  logic signed [15:0] beat_max;
  logic [15:0]        cur_s, e_lin, e_val;
  logic [16:0]        diff, recip;
  logic [32:0]        trial;

  assign cfg_bad   = (cfg_cols == 16'd0) || (cfg_cols > 16'(MAX_COLS)) || (cfg_rows == 16'd0);
  assign last_beat = ({1'b0, beat_q, 3'b000} + (AW+1)'(8)) >= cols_q;
  assign last_idx  = ({1'b0, idx_q} == cols_q - (AW+1)'(1));
  assign more_rows = ({1'b0, row_q} + 17'd1) < {1'b0, rows_q};
  assign recip     = quo_q;
  assign trial     = {rem_q, dvd_q[31]};

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [AW-1:0] col;
    logic [32:0]   prod, prod_sh;
    assign col         = {beat_q, 3'(k)};
    assign lane_s[k]   = s_data[16*k +: 16];
    assign lane_ok[k]  = {1'b0, col} < cols_q;
`ifdef ATTN_SOFTMAX_MASK_EN
    assign lane_use[k] = lane_ok[k] && (16'(col) <= row_q);
`else
    assign lane_use[k] = lane_ok[k];
`endif
    assign prod        = 33'(buf_q[col]) * 33'(recip);
    assign prod_sh     = prod >> 15;
    assign lane_p[k]   = !lane_ok[k] ? 16'd0 :
                         (prod_sh > 33'h0FFFF) ? 16'hFFFF : prod_sh[15:0];
  end

  always_comb begin
    beat_max = max_q;
    for (int k = 0; k < 8; k++)
      if (lane_use[k] && ($signed(lane_s[k]) > beat_max)) beat_max = lane_s[k];
  end

  // d >= 0 always, so modulo-2^17 subtraction yields the true distance from max
  assign cur_s = buf_q[idx_q];
  assign diff  = {max_q[15], max_q} - {cur_s[15], cur_s};
  assign e_lin = 16'd32768 - {2'b00, diff[7:0], 6'b000000};

  always_comb begin
    e_val = (diff[16:8] >= 9'd16) ? 16'd0 : (e_lin >> diff[11:8]);
`ifdef ATTN_SOFTMAX_MASK_EN
    if (16'(idx_q) > row_q) e_val = 16'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !cfg_bad) state_d = S_LOAD;
      S_LOAD: if (s_valid && last_beat) state_d = S_EXP;
      S_EXP:  if (last_idx) state_d = S_DIV;
      S_DIV:  if (div_cnt_q == '0) state_d = S_EMIT;
      S_EMIT: if (m_ready && last_beat) state_d = more_rows ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == S_LOAD);
    m_valid = (state_q == S_EMIT);
    busy    = (state_q != S_IDLE);
    done    = done_q;
    error   = error_q;
    m_addr  = 32'd0;
    m_data  = '0;
    if (state_q == S_EMIT) begin
      m_addr = base_q + 32'({beat_q, 3'b000});
      for (int k = 0; k < 8; k++) m_data[16*k +: 16] = lane_p[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0; row_q <= '0; cols_q <= '0; beat_q <= '0; idx_q <= '0;
      div_cnt_q <= '0; max_q <= '0; sum_q <= '0; rem_q <= '0; quo_q <= '0;
      dvd_q <= '0; base_q <= '0; done_q <= 1'b0; error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          if (cfg_bad) error_q <= 1'b1;
          else begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols[AW:0];
            row_q  <= '0;
            base_q <= '0;
            beat_q <= '0;
            max_q  <= 16'sh8000;
          end
        end
        S_LOAD: if (s_valid) begin
          max_q <= beat_max;
          if (last_beat) begin
            beat_q <= '0;
            idx_q  <= '0;
            sum_q  <= '0;
          end else beat_q <= beat_q + 1'b1;
        end
        S_EXP: begin
          sum_q <= sum_q + {16'd0, e_val};
          idx_q <= idx_q + 1'b1;
          if (last_idx) begin
            div_cnt_q <= DCW'(DIV_ITERS - 1);
            rem_q     <= '0;
            quo_q     <= '0;
            dvd_q     <= 32'h8000_0000;
          end
        end
        S_DIV: begin
          if (trial >= {1'b0, sum_q}) begin
            rem_q <= 32'(trial - {1'b0, sum_q});
            quo_q <= {quo_q[15:0], 1'b1};
          end else begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[15:0], 1'b0};
          end
          dvd_q     <= {dvd_q[30:0], 1'b0};
          div_cnt_q <= div_cnt_q - 1'b1;
        end
        S_EMIT: if (m_ready) begin
          if (last_beat) begin
            beat_q <= '0;
            if (more_rows) begin
              row_q  <= row_q + 16'd1;
              base_q <= base_q + 32'(cols_q);
              max_q  <= 16'sh8000;
            end else done_q <= 1'b1;
          end else beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && s_valid) begin
      for (int k = 0; k < 8; k++)
        if (lane_ok[k]) buf_q[{beat_q, 3'(k)}] <= lane_s[k];
    end else if (state_q == S_EXP) begin
      buf_q[idx_q] <= e_val;
    end
  end

endmodule

// File: tb/tb_nvdla_attn_softmax.sv
// Self-checking bench for nvdla_attn_softmax: directed vectors, corner sequences, random rows vs. model.
module tb_nvdla_attn_softmax;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  cfg_rows = '0;
  logic [15:0]  cfg_cols = '0;
  logic         s_valid = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_ready;
  logic         m_valid;
  logic [127:0] m_data;
  logic [31:0]  m_addr;
  logic         m_ready = 1'b0;
  logic         busy, done, error;

  int checks = 0;
  int errors = 0;
  int sc[$];
  int ep[$];

  typedef struct {
    int rows; int cols; int s0; int s1; int p0; int p1; int pr;
  } vec_t;

  nvdla_attn_softmax dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_addr(m_addr), .m_ready(m_ready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference softmax straight from the arithmetic definition (integer math on whole rows).
  function automatic void model(input int rows, input int cols);
    ep.delete();
    for (int r = 0; r < rows; r++) begin
      int     mx;
      longint sum;
      longint rcp;
      int     e[$];
      mx = -100000;
      sum = 0;
      for (int c = 0; c < cols; c++) begin
        bit use_c;
        use_c = 1'b1;
`ifdef ATTN_SOFTMAX_MASK_EN
        use_c = (c <= r);
`endif
        if (use_c && sc[r*cols+c] > mx) mx = sc[r*cols+c];
      end
      for (int c = 0; c < cols; c++) begin
        int d, ev;
        bit use_c;
        use_c = 1'b1;
`ifdef ATTN_SOFTMAX_MASK_EN
        use_c = (c <= r);
`endif
        d = mx - sc[r*cols+c];
        if (!use_c || d / 256 >= 16) ev = 0;
        else ev = (32768 - (d % 256) * 64) / (1 << (d / 256));
        e.push_back(ev);
        sum += ev;
      end
      rcp = (longint'(1) << 31) / sum;
      for (int c = 0; c < cols; c++) begin
        longint p;
        p = (longint'(e[c]) * rcp) / 32768;
        if (p > 65535) p = 65535;
        ep.push_back(int'(p));
      end
    end
  endfunction

  task automatic run_job(input string tag, input int rows, input int cols,
                         input int vpct, input int rpct, input int stall_at);
    int nb, tot, ib, ob, cyc, stall, col, row, bt;
    logic [127:0] ed;
    logic [31:0]  ea;
    nb = (cols + 7) / 8;
    tot = rows * nb;
    ib = 0; ob = 0; cyc = 0; stall = 0;
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'(rows); cfg_cols = 16'(cols);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 128'(busy), 128'(1));
    while (ob < tot && cyc < 20000) begin
      if (ib < tot && int'($urandom_range(0, 99)) < vpct) begin
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
          col = (ib % nb) * 8 + k;
          s_data[16*k +: 16] = (col < cols) ? 16'(sc[(ib / nb) * cols + col]) : 16'($urandom);
        end
      end else begin
        s_valid = 1'b0;
        s_data = 128'($urandom);
      end
      if (stall_at == ob && stall < 5) m_ready = 1'b0;
      else m_ready = (int'($urandom_range(0, 99)) < rpct);
      if (s_valid && s_ready) ib++;
      if (m_valid) begin
        row = ob / nb;
        bt = ob % nb;
        ea = 32'(row * cols + bt * 8);
        ed = '0;
        for (int k = 0; k < 8; k++) begin
          col = bt * 8 + k;
          if (col < cols) ed[16*k +: 16] = 16'(ep[row * cols + col]);
        end
        if (stall_at == ob && stall < 5) begin
          check({tag, " stall data"}, m_data, ed);
          check({tag, " stall addr"}, 128'(m_addr), 128'(ea));
          stall++;
        end else if (m_ready) begin
          check({tag, " data"}, m_data, ed);
          check({tag, " addr"}, 128'(m_addr), 128'(ea));
          ob++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (ob < tot) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d beats expected %0d", tag, ob, tot);
    end else begin
      check({tag, " done pulse"}, 128'(done), 128'(1));
      check({tag, " idle after done"}, 128'(busy), 128'(0));
      @(negedge clk);
      check({tag, " done clears"}, 128'(done), 128'(0));
    end
  endtask

  initial begin
    vec_t vt[6];
    int   bad_c[4];
    int   bad_r[4];
    int   n, rows, cols, base, v, mode;
    vt[0] = '{1, 8,    0,    0,  8192,  8192, 8192};
    vt[1] = '{1, 8, 2048,    0, 63791,   249,  249};
    vt[2] = '{1, 2,    0, -128, 37449, 28086,    0};
    vt[3] = '{2, 10,   0,    0,  6553,  6553, 6553};
    vt[4] = '{1, 1, 4660,    0, 65535,     0,    0};
    vt[5] = '{1, 256,  0,    0,   256,   256,  256};
    bad_c = '{0, 300, 8, 257};
    bad_r = '{1, 1, 0, 1};

    repeat (3) @(negedge clk);
    check("rst m_valid", 128'(m_valid), 128'(0));
    check("rst m_data",  m_data,        128'(0));
    check("rst m_addr",  128'(m_addr),  128'(0));
    check("rst s_ready", 128'(s_ready), 128'(0));
    check("rst busy",    128'(busy),    128'(0));
    check("rst done",    128'(done),    128'(0));
    check("rst error",   128'(error),   128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start = 1'b1; cfg_cols = 16'(bad_c[i]); cfg_rows = 16'(bad_r[i]);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("bad cfg %0d error", i), 128'(error), 128'(1));
      check($sformatf("bad cfg %0d busy", i), 128'(busy), 128'(0));
      @(negedge clk);
      check($sformatf("bad cfg %0d error clears", i), 128'(error), 128'(0));
    end

`ifndef ATTN_SOFTMAX_MASK_EN
    for (int i = 0; i < 6; i++) begin
      sc.delete();
      ep.delete();
      for (int r = 0; r < vt[i].rows; r++)
        for (int c = 0; c < vt[i].cols; c++) begin
          sc.push_back(c == 0 ? vt[i].s0 : (c == 1 ? vt[i].s1 : 0));
          ep.push_back(c == 0 ? vt[i].p0 : (c == 1 ? vt[i].p1 : vt[i].pr));
        end
      run_job($sformatf("vec%0d", i), vt[i].rows, vt[i].cols, 100, 100, -1);
    end
`else
    sc = '{0, 0, 0, 0};
    ep = '{65535, 0, 32768, 32768};
    run_job("mask", 2, 2, 100, 100, -1);
`endif

    sc.delete();
    for (int c = 0; c < 16; c++) sc.push_back(int'($urandom_range(0, 2047)) - 1024);
    model(1, 16);
    run_job("stall", 1, 16, 100, 100, 1);

    // reset landing in the middle of the reciprocal divide
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'd1; cfg_cols = 16'd8;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    s_data = '0;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("div busy", 128'(busy), 128'(1));
    check("div no output", 128'(m_valid), 128'(0));
    rst_n = 1'b0;
    #1;
    check("rst mid m_valid", 128'(m_valid), 128'(0));
    check("rst mid m_data",  m_data,        128'(0));
    check("rst mid m_addr",  128'(m_addr),  128'(0));
    check("rst mid busy",    128'(busy),    128'(0));
    check("rst mid s_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < 12; j++) begin
      rows = int'($urandom_range(1, 3));
      cols = (j == 11) ? 256 : int'($urandom_range(1, 40));
      mode = int'($urandom_range(0, 3));
      sc.delete();
      for (int r = 0; r < rows; r++) begin
        base = int'($urandom_range(0, 65535)) - 32768;
        for (int c = 0; c < cols; c++) begin
          if (mode == 0) v = int'($urandom_range(0, 65535)) - 32768;
          else begin
            v = base - int'($urandom_range(0, 6144));
            if (v < -32768) v = -32768;
          end
          sc.push_back(v);
        end
      end
      model(rows, cols);
      run_job($sformatf("rand%0d", j), rows, cols,
              int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvdla_attn_softmax.md
Name: nvdla_attn_softmax

Overview:
Row-wise softmax stage directly downstream of the attention score matrix multiplier.
- Consumes the scaled QK^T score stream: 8 x 16-bit lanes per beat, row-major.
- Emits normalized probabilities in the same packing to the attention-V multiply stage.
- Uses a base-2 linear exp approximation, one sequential reciprocal per row, and 8 parallel output multipliers.

Parameters:
MAX_COLS, 256, max row length (elements); row buffer depth
DIV_ITERS, 32, reciprocal divider iterations (fixed; not user-tunable)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin job (sampled only in IDLE)
cfg_rows  in  16  rows in job
cfg_cols  in  16  elements per row
s_valid  in  1  input beat valid
s_data  in  128  8 signed Q8.8 scores; lane i = bits [16i+15:16i]
s_ready  out  1  input ready
m_valid  out  1  output beat valid
m_data  out  128  8 unsigned Q0.16 probabilities
m_addr  out  32  element index of lane 0 = row*cfg_cols + col
m_ready  in  1  output ready
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse after last output beat of job accepted
error  out  1  1-cycle pulse on rejected start

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset mid-job aborts immediately; no partial output.
- Handshake: transfer when valid&&ready. m_data/m_addr/m_valid held stable while m_valid&&!m_ready. s_ready=1 only in LOAD.
- IDLE:
  - start with cfg_cols==0, cfg_cols>MAX_COLS, or cfg_rows==0 -> error pulse; stay IDLE.
  - Otherwise latch cfg; row=0 -> LOAD. start outside IDLE ignored.
- LOAD:
  - Accept ceil(cols/8) beats; store lanes with col<cols into buffer.
  - Lanes with col>=cols on the final beat are ignored.
  - Running signed max over stored lanes.
  - After last beat -> EXP.
- EXP: 1 element/cycle, cols cycles.
  - d = max - s (17-bit, >=0); i = d[16:8], f = d[7:0].
  - e = (32768 - (f<<6)) >> i, or e = 0 if i>=16. e is Q1.15 and overwrites the buffer entry.
  - sum += e, 32-bit. sum >= 32768 is guaranteed.
  - -> DIV.
- DIV: restoring divider, exactly 32 cycles, recip = floor(2^31 / sum), 17-bit -> EMIT.
- EMIT: per beat, lane k: p = (e*recip)>>15, saturated to 0xFFFF.
  - Lanes with col>=cols output 0.
  - m_addr = row*cols + beat*8.
  - After last beat accepted: row+1<rows -> LOAD (row++); else done pulse -> IDLE.
- Per-row latency excluding stalls: ceil(cols/8) + cols + 32 + ceil(cols/8) cycles, plus 1 cycle per state transition.

Optional Feature:
ATTN_SOFTMAX_MASK_EN: causal mask.
- Defined: elements with col > row are excluded from max, forced to e=0, and output 0.
- Undefined: all elements participate; no mask logic is present.

Test Plan:
- rows=1, cols=8, all scores 0x0000 -> sum=262144, recip=8192, all 8 lanes 0x2000, m_addr=0, done pulse.
- rows=1, cols=8, lane0=0x0800, others 0 -> e={32768, 7x128}, recip=63791, lane0=63791, lanes1-7=249.
- cols=10, rows=2, scores 0 -> per row 2 beats with m_addr 0,8 (row0) and 10,18 (row1). Valid lanes=6553 (recip=6553). Second-beat lanes 2-7 = 0.
- Fractional: lane0=0x0000, lane1=0xFF80 (-0.5), cols=2 -> e1=24576, sum=57344, recip=37449, outputs 37449 / 28086.
- m_ready held low 5 cycles mid-EMIT -> m_data/m_addr stable; no beat lost or duplicated. cfg_cols=0 or 300 start -> error pulse, busy stays 0.
- Reset asserted during DIV -> all outputs 0 next edge. With ATTN_SOFTMAX_MASK_EN, rows=2, cols=2, scores 0: row0 = {0xFFFF, 0}, row1 = {0x8000, 0x8000}.
